// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage constants: reset/handler vectors, legal instruction window,
// and the address-error code also used by CP0 and later exception checks.
package fetch_pc_unit_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_LO      = 32'h0000_3000;
  localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

  localparam logic [4:0]  EXC_ADEL   = 5'd4;

  typedef enum logic [2:0] {
    NPC_RESET   = 3'd0,
    NPC_HANDLER = 3'd1,
    NPC_HOLD    = 3'd2,
    NPC_EPC     = 3'd3,
    NPC_BRANCH  = 3'd4,
    NPC_SEQ     = 3'd5
  } npc_src_e;

  // A fetch address faults when misaligned or outside the instruction window.
  function automatic logic addr_fault(input logic [31:0] pc,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_npc_sel.sv
// Next-PC selection: resolves the redirect sources in fixed priority order
// rst > m_req > stall > eret > taken branch > sequential.
module fetch_pc_unit_npc_sel #(
  parameter logic [31:0] RESET_PC   = fetch_pc_unit_pkg::RESET_PC,
  parameter logic [31:0] HANDLER_PC = fetch_pc_unit_pkg::HANDLER_PC
) (
  input  logic        rst,
  input  logic        m_req,
  input  logic        stall,
  input  logic        d_is_eret,
  input  logic        d_br_taken,
  input  logic [31:0] pc,
  input  logic [31:0] epc,
  input  logic [31:0] d_br_target,
  output logic [31:0] npc
);
  import fetch_pc_unit_pkg::*;

  npc_src_e src_s;

  // Priority encode the redirect source; m_req deliberately outranks stall.
  always_comb begin
    src_s = NPC_SEQ;
    if (rst) begin
      src_s = NPC_RESET;
    end else if (m_req) begin
      src_s = NPC_HANDLER;
    end else if (stall) begin
      src_s = NPC_HOLD;
    end else if (d_is_eret) begin
      src_s = NPC_EPC;
    end else if (d_br_taken) begin
      src_s = NPC_BRANCH;
    end else begin
      src_s = NPC_SEQ;
    end
  end

  // Select the next PC value for the chosen source.
  always_comb begin
    npc = pc + 32'd4;
    case (src_s)
      NPC_RESET:   npc = RESET_PC;
      NPC_HANDLER: npc = HANDLER_PC;
      NPC_HOLD:    npc = pc;
      NPC_EPC:     npc = epc;
      NPC_BRANCH:  npc = d_br_target;
      NPC_SEQ:     npc = pc + 32'd4;
      default:     npc = RESET_PC;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC unit: PC register, link value, fetch address-error detection
// and instruction masking; next-PC choice lives in the npc_sel sub-module.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = fetch_pc_unit_pkg::RESET_PC,
  parameter logic [31:0] HANDLER_PC = fetch_pc_unit_pkg::HANDLER_PC,
  parameter logic [31:0] IM_LO      = fetch_pc_unit_pkg::IM_LO,
  parameter logic [31:0] IM_HI      = fetch_pc_unit_pkg::IM_HI
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        m_req,
  input  logic        d_is_eret,
  input  logic [31:0] epc,
  input  logic        d_br_taken,
  input  logic [31:0] d_br_target,
  input  logic        d_is_br,
  input  logic [31:0] i_rdata,
  output logic [31:0] i_addr,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic [31:0] f_adder,
  output logic        f_exc,
  output logic [4:0]  f_exc_code,
  output logic        f_is_delay
);
  import fetch_pc_unit_pkg::*;

  logic [31:0] pc_r;
  logic [31:0] npc_s;
  logic        exc_s;

  fetch_pc_unit_npc_sel #(
    .RESET_PC   (RESET_PC),
    .HANDLER_PC (HANDLER_PC)
  ) npc_sel (
    .rst         (rst),
    .m_req       (m_req),
    .stall       (stall),
    .d_is_eret   (d_is_eret),
    .d_br_taken  (d_br_taken),
    .pc          (pc_r),
    .epc         (epc),
    .d_br_target (d_br_target),
    .npc         (npc_s)
  );

  // PC register; the synchronous reset is folded into npc_sel's priority chain.
  always_ff @(posedge clk) begin
    pc_r <= npc_s;
  end

  // A faulting PC keeps sequencing; only the fetched word is suppressed.
  assign exc_s      = addr_fault(pc_r, IM_LO, IM_HI);

  assign f_pc       = pc_r;
  assign i_addr     = pc_r;
  assign f_adder    = pc_r + 32'd8;
  assign f_exc      = exc_s;
  assign f_exc_code = exc_s ? EXC_ADEL : 5'd0;
  assign f_instr    = exc_s ? 32'h0000_0000 : i_rdata;
  assign f_is_delay = d_is_br & ~d_is_eret;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed, table-driven bench for fetch_pc_unit: each row drives one cycle of
// inputs and lists the hand-computed outputs seen just after that clock edge.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, m_req, d_is_eret, d_br_taken, d_is_br;
  logic [31:0] epc, d_br_target, i_rdata;
  logic [31:0] i_addr, f_pc, f_instr, f_adder;
  logic        f_exc, f_is_delay;
  logic [4:0]  f_exc_code;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, stall, m_req, eret, br_taken, is_br;
    logic [31:0] epc, target, rdata;
    logic [31:0] exp_pc, exp_adder, exp_instr;
    logic        exp_exc, exp_delay;
  } vec_t;

  vec_t vecs[$];

  fetch_pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .m_req(m_req), .d_is_eret(d_is_eret),
    .epc(epc), .d_br_taken(d_br_taken), .d_br_target(d_br_target),
    .d_is_br(d_is_br), .i_rdata(i_rdata), .i_addr(i_addr), .f_pc(f_pc),
    .f_instr(f_instr), .f_adder(f_adder), .f_exc(f_exc),
    .f_exc_code(f_exc_code), .f_is_delay(f_is_delay)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, st, mr, er, bt, ib,
                     input logic [31:0] e, t, rd, pc, adder, instr,
                     input logic exc, dly);
    vec_t v;
    v.rst = r; v.stall = st; v.m_req = mr; v.eret = er; v.br_taken = bt; v.is_br = ib;
    v.epc = e; v.target = t; v.rdata = rd;
    v.exp_pc = pc; v.exp_adder = adder; v.exp_instr = instr;
    v.exp_exc = exc; v.exp_delay = dly;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, st, mr, er, bt, ib,
                       input logic [31:0] e, t, rd);
    @(negedge clk);
    rst = r; stall = st; m_req = mr; d_is_eret = er; d_br_taken = bt; d_is_br = ib;
    epc = e; d_br_target = t; i_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input logic [31:0] pc,
                           input logic [31:0] adder, input logic [31:0] instr,
                           input logic exc, input logic dly);
    chk("f_pc",       idx, f_pc, pc);
    chk("i_addr",     idx, i_addr, pc);
    chk("f_adder",    idx, f_adder, adder);
    chk("f_exc",      idx, {31'd0, f_exc}, {31'd0, exc});
    chk("f_exc_code", idx, {27'd0, f_exc_code}, exc ? 32'd4 : 32'd0);
    chk("f_instr",    idx, f_instr, instr);
    chk("f_is_delay", idx, {31'd0, f_is_delay}, {31'd0, dly});
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; m_req = 1'b0; d_is_eret = 1'b0;
    d_br_taken = 1'b0; d_is_br = 1'b0;
    epc = 32'd0; d_br_target = 32'd0; i_rdata = 32'd0;

    //  rst st mr er bt ib  epc            target         rdata          pc             adder          instr          exc dly
    // reset, then sequential fetch
    add(1, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h1111_0000, 32'h0000_3000, 32'h0000_3008, 32'h1111_0000, 0, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h1111_0001, 32'h0000_3004, 32'h0000_300C, 32'h1111_0001, 0, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h1111_0002, 32'h0000_3008, 32'h0000_3010, 32'h1111_0002, 0, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h1111_0003, 32'h0000_300C, 32'h0000_3014, 32'h1111_0003, 0, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h1111_0004, 32'h0000_3010, 32'h0000_3018, 32'h1111_0004, 0, 0);
    // taken branch held by stall for two cycles, then released
    add(0, 1, 0, 0, 1, 1, 32'h0,         32'h0000_3100, 32'h2222_0000, 32'h0000_3010, 32'h0000_3018, 32'h2222_0000, 0, 1);
    add(0, 1, 0, 0, 1, 1, 32'h0,         32'h0000_3100, 32'h2222_0001, 32'h0000_3010, 32'h0000_3018, 32'h2222_0001, 0, 1);
    add(0, 0, 0, 0, 1, 1, 32'h0,         32'h0000_3100, 32'h2222_0002, 32'h0000_3100, 32'h0000_3108, 32'h2222_0002, 0, 1);
    add(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h2222_0003, 32'h0000_3104, 32'h0000_310C, 32'h2222_0003, 0, 0);
    // m_req beats stall and eret; then eret alone (no delay slot even with d_is_br)
    add(0, 1, 1, 1, 0, 0, 32'h0000_3040, 32'h0,         32'h3333_0000, 32'h0000_4180, 32'h0000_4188, 32'h3333_0000, 0, 0);
    add(0, 0, 0, 1, 0, 1, 32'h0000_3040, 32'h0,         32'h3333_0001, 32'h0000_3040, 32'h0000_3048, 32'h3333_0001, 0, 0);
    add(0, 0, 0, 1, 1, 1, 32'h0000_3200, 32'h0000_3300, 32'h3333_0002, 32'h0000_3200, 32'h0000_3208, 32'h3333_0002, 0, 0);
    // walk off the top of the window: fault, keep sequencing, recover via m_req
    add(0, 0, 0, 0, 1, 1, 32'h0,         32'h0000_6FF8, 32'h4444_0000, 32'h0000_6FF8, 32'h0000_7000, 32'h4444_0000, 0, 1);
    add(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'h0000_6FFC, 32'h0000_7004, 32'hFFFF_FFFF, 0, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'h0000_7000, 32'h0000_7008, 32'h0000_0000, 1, 0);
    add(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'h0000_7004, 32'h0000_700C, 32'h0000_0000, 1, 0);
    add(0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h4444_0001, 32'h0000_4180, 32'h0000_4188, 32'h4444_0001, 0, 0);
    // misaligned branch target, then handler
    add(0, 0, 0, 0, 1, 1, 32'h0,         32'h0000_3002, 32'h5555_0000, 32'h0000_3002, 32'h0000_300A, 32'h0000_0000, 1, 1);
    add(0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h5555_0001, 32'h0000_4180, 32'h0000_4188, 32'h5555_0001, 0, 0);
    // 32-bit wrap of both PC and link value, below-window fault
    add(0, 0, 0, 0, 1, 1, 32'h0,         32'hFFFF_FFFC, 32'h6666_0000, 32'hFFFF_FFFC, 32'h0000_0004, 32'h0000_0000, 1, 1);
    add(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h6666_0001, 32'h0000_0000, 32'h0000_0008, 32'h0000_0000, 1, 0);
    add(0, 0, 0, 1, 0, 0, 32'h0000_2FFC, 32'h0,         32'h6666_0002, 32'h0000_2FFC, 32'h0000_3004, 32'h0000_0000, 1, 0);
    // reset overrides m_req, stall and a pending redirect
    add(1, 1, 1, 1, 1, 1, 32'h0000_3040, 32'h0000_3100, 32'h7777_0000, 32'h0000_3000, 32'h0000_3008, 32'h7777_0000, 0, 0);
    add(1, 0, 0, 0, 1, 1, 32'h0,         32'h0000_5000, 32'h7777_0001, 32'h0000_3000, 32'h0000_3008, 32'h7777_0001, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].m_req, vecs[i].eret,
            vecs[i].br_taken, vecs[i].is_br, vecs[i].epc, vecs[i].target, vecs[i].rdata);
      check_all(i, vecs[i].exp_pc, vecs[i].exp_adder, vecs[i].exp_instr,
                vecs[i].exp_exc, vecs[i].exp_delay);
    end

    // Long stall on a fresh stream: PC frozen at 3004 for five cycles, then resumes.
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h8888_0000);
    check_all(100, 32'h0000_3004, 32'h0000_300C, 32'h8888_0000, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 0, 1, 1, 1, 32'h0000_3500, 32'h0000_3600, 32'h8888_0100 + k);
      check_all(101 + k, 32'h0000_3004, 32'h0000_300C, 32'h8888_0100 + k, 1'b0, 1'b0);
    end
    // Stall released with eret and branch both pending: eret wins.
    drive(0, 0, 0, 1, 1, 1, 32'h0000_3500, 32'h0000_3600, 32'h8888_0200);
    check_all(110, 32'h0000_3500, 32'h0000_3508, 32'h8888_0200, 1'b0, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h8888_0201);
    check_all(111, 32'h0000_3504, 32'h0000_350C, 32'h8888_0201, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  RESET_PC 32'h0000_3000: PC after reset.
  HANDLER_PC 32'h0000_4180: exception/interrupt entry.
  IM_LO 32'h0000_3000: lowest legal fetch address.
  IM_HI 32'h0000_6FFC: highest legal fetch address.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  clock.
  rst  in  1  reset, synchronous, active-high.
  stall  in  1  hazard stall from D; hold PC.
  m_req  in  1  exception/interrupt taken in M; redirect to handler.
  d_is_eret  in  1  eret in D; redirect to EPC.
  epc  in  32  return address from CP0.
  d_br_taken  in  1  branch/jump in D resolved taken.
  d_br_target  in  32  branch/jump target.
  d_is_br  in  1  D holds any branch/jump (taken or not).
  i_rdata  in  32  instruction memory read data for i_addr.
  i_addr  out  32  instruction memory address (= f_pc).
  f_pc  out  32  current fetch PC.
  f_instr  out  32  fetched instruction, masked on exception.
  f_adder  out  32  link value, f_pc + 8.
  f_exc  out  1  fetch address error (AdEL) flag.
  f_exc_code  out  5  5'd4 when f_exc, else 5'd0.
  f_is_delay  out  1  F instruction is a delay-slot instruction.

Function
REQ-003 PC register SHALL update on posedge clk with priority: rst > m_req > stall > d_is_eret > d_br_taken > sequential.
REQ-004 rst: PC SHALL load RESET_PC.
REQ-005 m_req: PC SHALL load HANDLER_PC, even when stall is high.
REQ-006 stall (no m_req): PC SHALL hold its value.
REQ-007 d_is_eret (no m_req, no stall): PC SHALL load epc; f_is_delay SHALL be 0 that cycle (eret has no delay slot).
REQ-008 d_br_taken (none of the above): PC SHALL load d_br_target.
REQ-009 Otherwise PC SHALL load PC + 4, modulo 2^32 (wraps 32'hFFFF_FFFC -> 0).
REQ-010 f_adder SHALL be PC + 8, modulo 2^32, combinational.
REQ-011 f_exc SHALL be 1 iff PC[1:0] != 0, PC < IM_LO, or PC > IM_HI; combinational from PC.
REQ-012 While f_exc = 1, f_instr SHALL be 32'h0000_0000; otherwise f_instr = i_rdata.
REQ-013 f_is_delay SHALL equal d_is_br & ~d_is_eret, combinational.
REQ-014 A faulting PC SHALL NOT stop sequencing; PC continues per REQ-003 until m_req redirects it.
REQ-015 Read latency SHALL be zero cycles: i_addr = f_pc; i_rdata is consumed in the same cycle.
REQ-016 Simultaneous m_req and d_is_eret: m_req wins. Simultaneous stall and d_br_taken: PC holds; the branch is re-presented while stalled.

Reset
REQ-017 After rst the following SHALL hold:
  f_pc = i_addr = RESET_PC.
  f_adder = RESET_PC + 8.
  f_exc = 0 and f_exc_code = 0, given default parameters.
REQ-018 rst asserted mid-operation (during stall, m_req or a redirect) SHALL override everything on that edge.

Structure
REQ-019 A shared package SHALL hold:
  RESET_PC, HANDLER_PC, IM_LO, IM_HI.
  Exception code constant EXC_ADEL = 5'd4 (shared with CP0 and the later-stage exception checks).
REQ-020 One combinational sub-module, npc_sel, SHALL compute the next PC from the REQ-003 priority inputs; the PC register and exception/masking logic SHALL stay in fetch_pc_unit.

Verification
REQ-021 Sequential fetch: rst for 1 cycle, then 4 idle cycles -> f_pc = 3000, 3004, 3008, 300C, 3010; f_adder = f_pc + 8 each cycle.
REQ-022 Branch with stall:
  d_br_taken = 1, d_br_target = 32'h3100, stall = 1 for 2 cycles -> PC holds.
  Stall released -> next f_pc = 3100.
  f_is_delay = d_is_br throughout.
REQ-023 Redirect priority:
  m_req = 1 with stall = 1 and d_is_eret = 1, epc = 32'h3040 -> next f_pc = 4180.
  Then d_is_eret alone -> next f_pc = 3040, with f_is_delay = 0.
REQ-024 Range fault: PC reaches 6FFC, then advances -> f_pc = 7000, f_exc = 1, f_exc_code = 4, f_instr = 0 while i_rdata = 32'hFFFF_FFFF.
REQ-025 Misaligned target: d_br_target = 32'h3002 taken -> f_exc = 1 next cycle; m_req -> f_pc = 4180 and f_exc = 0.
REQ-026 Mid-operation reset: rst during m_req and stall -> f_pc = 3000 on the next edge.
